security_timer_sched: RTL and testbench

Shared timeout engine for the security system. Several requesters (keypad entry timeout, siren duration, door-lock hold, display blank) each need a millisecond-scale delay. Instead of one divider per requester, this block time-shares one prescaler and one down-counter. It grants the timer round-robin and reports expiry with a one-cycle `done` pulse to the owner.

---
 rtl/security_timer_pkg.sv | 17 +
 rtl/security_timer_sched_tick_prescaler.sv | 25 ++
 rtl/security_timer_sched.sv | 138 +++++++++++++
 tb/tb_security_timer_sched.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/security_timer_pkg.sv
// Shared types and helpers for the security timer scheduler.
package security_timer_pkg;

  localparam int TICK_HZ_DEF = 1000;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    COUNT,
    DONE
  } tsched_state_t;

  function automatic int presc_calc(input int clk_hz, input int tick_hz);
    return clk_hz / tick_hz;
  endfunction

endpackage

// File: rtl/security_timer_sched_tick_prescaler.sv
// Clock-to-tick divider: counts 0..PRESC-1 while enabled, tick on the last count.
module tick_prescaler #(
  parameter int PRESC = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = $clog2(PRESC);

  logic [CW-1:0] cnt;
  logic          at_top;

  assign at_top = (cnt == CW'(PRESC - 1));
  assign tick   = en && at_top;

  always_ff @(posedge clk) begin
    if (rst || clr) cnt <= '0;
    else if (en)    cnt <= at_top ? '0 : cnt + 1'b1;
  end

endmodule

// File: rtl/security_timer_sched.sv
// Time-shared timeout engine: one prescaler and one down-counter granted round-robin.
// Build option SECURITY_TIMER_SCHED_CANCEL_EN lets the owner abort its delay.
module security_timer_sched
  import security_timer_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int CLK_HZ  = 100_000_000,
  parameter int TICK_HZ = TICK_HZ_DEF,
  parameter int DLY_W   = 16,
  localparam int OW     = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*DLY_W-1:0] dly,
  input  logic [NUM_REQ-1:0]       cancel,
  output logic [NUM_REQ-1:0]       ack,
  output logic [NUM_REQ-1:0]       done,
  output logic                     busy,
  output logic [OW-1:0]            owner,
  output logic                     tick
);

  localparam int PRESC = presc_calc(CLK_HZ, TICK_HZ);

  generate
    if (PRESC < 2) begin : g_presc_chk
      $error("security_timer_sched: CLK_HZ/TICK_HZ must be >= 2");
    end
    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_nreq_chk
      $error("security_timer_sched: NUM_REQ must be 2..8");
    end
  endgenerate

  tsched_state_t    state;
  logic [OW-1:0]    rr_ptr;
  logic [OW-1:0]    pick_idx;
  logic             pick_vld;
  logic [OW-1:0]    owner_nxt;
  logic [DLY_W-1:0] remaining;
  logic [DLY_W-1:0] dly_sel;
  logic             cancel_hit;
  logic             presc_clr;
  logic             presc_en;

`ifdef SECURITY_TIMER_SCHED_CANCEL_EN
  assign cancel_hit = cancel[owner];
`else
  logic unused_cancel;
  assign unused_cancel = ^cancel;
  assign cancel_hit    = 1'b0;
`endif

  // First asserted request at or after rr_ptr, wrapping.
  always_comb begin
    int idx;
    idx      = 0;
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!pick_vld && req[idx]) begin
        pick_vld = 1'b1;
        pick_idx = OW'(idx);
      end
    end
  end

  assign dly_sel   = dly[owner*DLY_W +: DLY_W];
  assign owner_nxt = (owner == OW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
  assign presc_clr = (state == LOAD);
  assign presc_en  = (state == COUNT);

  tick_prescaler #(.PRESC(PRESC)) u_presc (
    .clk  (clk),
    .rst  (rst),
    .clr  (presc_clr),
    .en   (presc_en),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ack       <= '0;
      done      <= '0;
      busy      <= 1'b0;
      owner     <= '0;
      rr_ptr    <= '0;
      remaining <= '0;
    end else begin
      ack  <= '0;
      done <= '0;
      case (state)
        IDLE: begin
          if (pick_vld) begin
            owner         <= pick_idx;
            ack[pick_idx] <= 1'b1;
            busy          <= 1'b1;
            state         <= LOAD;
          end
        end
        LOAD: begin
          remaining <= dly_sel;
          rr_ptr    <= owner_nxt;
          if (cancel_hit) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else if (dly_sel == '0) begin
            done[owner] <= 1'b1;
            state       <= DONE;
          end else begin
            state <= COUNT;
          end
        end
        COUNT: begin
          // An owner cancel beats a coincident final tick.
          if (cancel_hit) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else if (tick) begin
            remaining <= remaining - 1'b1;
            if (remaining == DLY_W'(1)) begin
              done[owner] <= 1'b1;
              state       <= DONE;
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_security_timer_sched.sv
// Bench for security_timer_sched: directed scenarios plus random traffic against a timeline model.
module tb_security_timer_sched;

  localparam int N   = 4;
  localparam int P   = 5;
  localparam int DW  = 16;
  localparam int INF = 1 << 30;
`ifdef SECURITY_TIMER_SCHED_CANCEL_EN
  localparam bit CEN = 1'b1;
`else
  localparam bit CEN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req, cancel, ack, done;
  logic [N*DW-1:0] dly;
  logic          busy, tick;
  logic [1:0]    owner;

  int total = 0, bad = 0, n = 0;

  // Model: one transaction at a time, described by its decision cycle, owner, delay, cancel cycle.
  bit act;
  int mo, mtd, md, mc, nd, rr;
  int dv[N];

  int ack_n, done_n, tick_cnt, done_cnt, t;
  int grants[$];

  security_timer_sched #(
    .NUM_REQ(N), .CLK_HZ(10), .TICK_HZ(2), .DLY_W(DW)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .dly(dly), .cancel(cancel),
    .ack(ack), .done(done), .busy(busy), .owner(owner), .tick(tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic [N-1:0] raise, input logic [N-1:0] drop,
                     input logic do_rst, input logic [N-1:0] cnc);
    int e_ack, e_done, e_busy, e_tick, k;
    bit found;
    @(negedge clk);
    n++;
    k      = n - mtd - 1;
    e_ack  = (act && n == mtd + 1) ? (1 << mo) : 0;
    e_done = (act && n == mtd + 2 + md*P && mc == INF) ? (1 << mo) : 0;
    e_busy = (act && n >= mtd + 1 && n <= mtd + 2 + md*P && n <= mc) ? 1 : 0;
    e_tick = (act && k >= P && k % P == 0 && k / P <= md && n <= mc) ? 1 : 0;
    chk("ack", 32'(ack), e_ack);
    chk("done", 32'(done), e_done);
    chk("busy", 32'(busy), e_busy);
    chk("tick", 32'(tick), e_tick);
    if (e_busy != 0) chk("owner", 32'(owner), mo);

    if (ack != 0) begin
      ack_n = n;
      for (int i = 0; i < N; i++) if (ack[i]) grants.push_back(i);
    end
    if (done != 0) begin done_n = n; done_cnt++; end
    if (tick) tick_cnt++;

    // Stimulus for cycle n; the owner lets go once acknowledged.
    if (act && n == mtd + 1) req[mo] = 1'b0;
    req = req & ~drop;
    for (int i = 0; i < N; i++)
      if (raise[i] && !req[i] && !(act && i == mo && n == mtd + 1)) begin
        req[i]          = 1'b1;
        dly[i*DW +: DW] = DW'(dv[i]);
      end
    rst    = do_rst;
    cancel = cnc;

    if (do_rst) begin
      act = 1'b0; rr = 0; nd = n + 1;
    end else begin
      if (CEN && act && cnc[mo] && mc == INF && n >= mtd + 1 && n <= mtd + 1 + md*P) begin
        mc = n; nd = n + 1;
      end
      if (n == nd) begin
        nd    = n + 1;
        found = 1'b0;
        for (int j = 0; j < N; j++) begin
          int idx;
          idx = (rr + j) % N;
          if (!found && req[idx]) begin
            found = 1'b1;
            act = 1'b1; mo = idx; mtd = n; md = int'(dly[idx*DW +: DW]);
            mc = INF; nd = n + 3 + md*P; rr = (idx + 1) % N;
          end
        end
      end
    end
  endtask

  task automatic idle(input int cnt);
    repeat (cnt) cyc('0, '0, 1'b0, '0);
  endtask

  task automatic do_reset();
    repeat (2) cyc('0, '0, 1'b1, '0);
    cyc('0, '0, 1'b0, '0);
  endtask

  initial begin
    rst = 1'b1; req = '0; cancel = '0; dly = '0;
    act = 1'b0; mo = 0; mtd = 0; md = 0; mc = INF; nd = 0; rr = 0;
    ack_n = 0; done_n = 0; tick_cnt = 0; done_cnt = 0; t = 0;
    for (int i = 0; i < N; i++) dv[i] = 0;

    // reset state
    repeat (3) cyc('0, '0, 1'b1, '0);
    cyc('0, '0, 1'b0, '0);
    chk("rst_owner", 32'(owner), 0);
    chk("rst_ack", 32'(ack), 0);

    // single request, dly=3
    dv[1] = 3;
    cyc(4'b0010, '0, 1'b0, '0); t = n;
    idle(20);
    chk("single_ack_t", ack_n, t + 1);
    chk("single_done_t", done_n, t + 17);

    // zero delay
    dv[0] = 0; tick_cnt = 0;
    cyc(4'b0001, '0, 1'b0, '0); t = n;
    idle(6);
    chk("zero_ack_t", ack_n, t + 1);
    chk("zero_done_t", done_n, t + 2);
    chk("zero_ticks", tick_cnt, 0);

    // round robin with all requests held
    do_reset();
    grants.delete();
    for (int i = 0; i < N; i++) dv[i] = 1;
    for (int j = 0; j < 80 && grants.size() < 5; j++) begin
      cyc(4'hF, '0, 1'b0, '0);
      if (ack_n == n && grants.size() > 1) chk("rr_gap", ack_n - done_n, 2);
    end
    chk("rr_count", grants.size(), 5);
    if (grants.size() >= 5)
      for (int i = 0; i < 5; i++) chk("rr_order", grants[i], i % N);
    cyc('0, 4'hF, 1'b0, '0);
    idle(12);

    // contention after wrap: owner 3 then 0 before 2
    do_reset();
    grants.delete();
    dv[3] = 1;
    cyc(4'b1000, '0, 1'b0, '0);
    idle(3);
    dv[0] = 2; dv[2] = 1;
    cyc(4'b0101, '0, 1'b0, '0);
    idle(40);
    chk("wrap_count", grants.size(), 3);
    if (grants.size() >= 3) begin
      chk("wrap_g0", grants[0], 3);
      chk("wrap_g1", grants[1], 0);
      chk("wrap_g2", grants[2], 2);
    end

    // reset mid-COUNT
    dv[1] = 4; done_cnt = 0;
    cyc(4'b0010, '0, 1'b0, '0); t = n;
    idle(7);
    cyc('0, '0, 1'b1, '0);
    cyc('0, '0, 1'b0, '0);
    chk("rstmid_busy", 32'(busy), 0);
    chk("rstmid_owner", 32'(owner), 0);
    idle(25);
    chk("rstmid_nodone", done_cnt, 0);

    // cancel coinciding with the final tick
    dv[2] = 2; done_cnt = 0; tick_cnt = 0;
    cyc(4'b0100, '0, 1'b0, '0); t = n;
    idle(10);
    cyc('0, '0, 1'b0, 4'b0100);
    idle(5);
    chk("cancel_done", done_cnt, CEN ? 0 : 1);
    chk("cancel_ticks", tick_cnt, 2);

    // random traffic
    for (int j = 0; j < 600; j++) begin
      logic [N-1:0] r, d, c;
      logic         rs;
      for (int i = 0; i < N; i++) dv[i] = $urandom_range(0, 3);
      r  = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      d  = ($urandom_range(0, 15) == 0) ? N'($urandom) : '0;
      c  = ($urandom_range(0, 9) == 0) ? N'($urandom) : '0;
      rs = ($urandom_range(0, 149) == 0);
      cyc(r, d, rs, c);
    end
    idle(30);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
